// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: walks a small combinational gate through every input
// combination, waits a settle interval per vector, and captures the gate
// output. Each captured bit is compared against an expected truth table.
// Optional build macro GATE_SWEEP_STOP_ON_FAIL_EN: when it is defined, the
// sweep ends at the first mismatching vector instead of running to the end.
module gate_sweep_ctrl #(
    parameter int                   N_IN          = 2,
    parameter int                   SETTLE_CYCLES = 1,
    parameter logic [(1<<N_IN)-1:0] EXPECTED      = 4'b0001
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   gate_y,
    output logic [N_IN-1:0]        stim,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [N_IN:0]          err_count,
    output logic [(1<<N_IN)-1:0]   captured,
    output logic [N_IN-1:0]        vec_idx
);

    localparam int              NVEC        = 1 << N_IN;
    localparam logic [7:0]      SETTLE_INIT = 8'(SETTLE_CYCLES);
    localparam logic [N_IN:0]   ERR_ONE     = (N_IN+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [N_IN-1:0]      vec_q, vec_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [N_IN:0]        err_q, err_d;
    logic [NVEC-1:0]      cap_q, cap_d;
    logic                 pass_q, pass_d;
    logic                 mismatch;
    logic                 stop;

    // State and result registers; reset wins over an in-flight sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            cap_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            cap_q   <= cap_d;
            pass_q  <= pass_d;
        end
    end

    // Next-state logic: results only change on an accepted start or in CAPTURE.
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        cap_d    = cap_q;
        pass_d   = pass_q;
        mismatch = 1'b0;
        stop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_APPLY;
                    vec_d   = '0;
                    err_d   = '0;
                    cap_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            S_APPLY: begin
                cnt_d   = SETTLE_INIT;
                state_d = (SETTLE_CYCLES == 0) ? S_CAPTURE : S_SETTLE;
            end
            S_SETTLE: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                cap_d[vec_q] = gate_y;
                mismatch     = (gate_y != EXPECTED[vec_q]);
                if (mismatch) begin
                    err_d = err_q + ERR_ONE;
                end
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
                stop = mismatch;
`else
                stop = 1'b0;
`endif
                if (stop || (&vec_q)) begin
                    state_d = S_DONE;
                    pass_d  = (err_d == '0);
                end else begin
                    vec_d   = vec_q + 1'b1;
                    state_d = S_APPLY;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the state; stim is zero outside the sweep.
    always_comb begin
        busy      = (state_q == S_APPLY) || (state_q == S_SETTLE) ||
                    (state_q == S_CAPTURE);
        done      = (state_q == S_DONE);
        stim      = busy ? vec_q : '0;
        pass      = pass_q;
        err_count = err_q;
        captured  = cap_q;
        vec_idx   = vec_q;
    end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb_gate_sweep_ctrl: two controllers (settle 1 and settle 0) each drive a
// gate modelled as a 4-entry lookup table, checked against a sweep model.
module tb_gate_sweep_ctrl;

    logic       clk;
    logic       rst;
    logic       start   [2];
    logic [3:0] tbl     [2];
    logic       gateY   [2];
    logic [1:0] stimW   [2];
    logic       busyW   [2];
    logic       doneW   [2];
    logic       passW   [2];
    logic [2:0] errW    [2];
    logic [3:0] capW    [2];
    logic [1:0] vecW    [2];

    int checks = 0;
    int passes = 0;

    gate_sweep_ctrl #(.N_IN(2), .SETTLE_CYCLES(1), .EXPECTED(4'b0001)) dut (
        .clk(clk), .rst(rst), .start(start[0]), .gate_y(gateY[0]),
        .stim(stimW[0]), .busy(busyW[0]), .done(doneW[0]), .pass(passW[0]),
        .err_count(errW[0]), .captured(capW[0]), .vec_idx(vecW[0])
    );

    gate_sweep_ctrl #(.N_IN(2), .SETTLE_CYCLES(0), .EXPECTED(4'b0001)) dut0 (
        .clk(clk), .rst(rst), .start(start[1]), .gate_y(gateY[1]),
        .stim(stimW[1]), .busy(busyW[1]), .done(doneW[1]), .pass(passW[1]),
        .err_count(errW[1]), .captured(capW[1]), .vec_idx(vecW[1])
    );

    // The gate under test is just a truth-table lookup on the applied vector.
    always_comb begin
        gateY[0] = tbl[0][stimW[0]];
        gateY[1] = tbl[1][stimW[1]];
    end

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something hangs outside the bounded loops.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        if (obs !== exp)
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        else
            passes++;
    endtask

    task automatic checkIdleZero(input int d);
        checkOutput("rstStim", 32'(stimW[d]), 0);
        checkOutput("rstBusy", 32'(busyW[d]), 0);
        checkOutput("rstDone", 32'(doneW[d]), 0);
        checkOutput("rstPass", 32'(passW[d]), 0);
        checkOutput("rstErr",  32'(errW[d]),  0);
        checkOutput("rstCap",  32'(capW[d]),  0);
        checkOutput("rstVec",  32'(vecW[d]),  0);
    endtask

    // One sweep on controller d with gate table t; expectations come from
    // the sweep rules: vector i is held settle+2 cycles, results compared
    // to the NOR table, optionally truncated at the first mismatch.
    task automatic applyStimulus(input int d, input logic [3:0] t, input bit poke);
        int         s;
        int         per;
        int         expErr;
        int         expVec;
        int         expLen;
        int         busyCnt;
        logic [3:0] expCap;
        logic [3:0] mism;
        s      = (d == 0) ? 1 : 0;
        per    = s + 2;
        tbl[d] = t;
        mism   = t ^ 4'b0001;
        expErr = $countones(mism);
        expVec = 3;
        expCap = t;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        if (mism != 4'b0000) begin
            for (int i = 3; i >= 0; i--)
                if (mism[i]) expVec = i;
            expErr = 1;
            expCap = t & 4'((2 << expVec) - 1);
        end
`endif
        expLen = (expVec + 1) * per;

        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        busyCnt = 0;
        while (busyW[d] && busyCnt < 100) begin
            checkOutput("stimSeq", 32'(stimW[d]), 32'(busyCnt / per));
            checkOutput("noEarlyDone", 32'(doneW[d]), 0);
            busyCnt++;
            if (poke && busyCnt == 3) start[d] = 1'b1;
            @(negedge clk);
            start[d] = 1'b0;
        end
        checkOutput("busyLen", 32'(busyCnt), 32'(expLen));
        checkOutput("donePulse", 32'(doneW[d]), 1);
        checkOutput("doneStim", 32'(stimW[d]), 0);
        checkOutput("pass", 32'(passW[d]), 32'(expErr == 0));
        checkOutput("errCount", 32'(errW[d]), 32'(expErr));
        checkOutput("captured", 32'(capW[d]), 32'(expCap));
        checkOutput("vecIdx", 32'(vecW[d]), 32'(expVec));
        if (poke) start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        checkOutput("doneOneCycle", 32'(doneW[d]), 0);
        checkOutput("idleBusy", 32'(busyW[d]), 0);
        @(negedge clk);
        checkOutput("startNotQueued", 32'(busyW[d]), 0);
        checkOutput("holdCaptured", 32'(capW[d]), 32'(expCap));
        checkOutput("holdErr", 32'(errW[d]), 32'(expErr));
        checkOutput("holdPass", 32'(passW[d]), 32'(expErr == 0));
    endtask

    initial begin
        int cyc;
        rst      = 1'b1;
        start[0] = 1'b0;
        start[1] = 1'b0;
        tbl[0]   = 4'b0001;
        tbl[1]   = 4'b0001;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkIdleZero(0);
        checkIdleZero(1);

        applyStimulus(0, 4'b0001, 1'b1);
        applyStimulus(0, 4'b1110, 1'b0);
        applyStimulus(0, 4'b0000, 1'b0);
        applyStimulus(1, 4'b0000, 1'b0);
        applyStimulus(1, 4'b0001, 1'b0);

        // Reset in the middle of a sweep, at vector 2.
        tbl[0]   = 4'b0001;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        cyc = 0;
        while (vecW[0] != 2'd2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("reachVec2", 32'(vecW[0]), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkIdleZero(0);
        applyStimulus(0, 4'b0001, 1'b0);

        for (int k = 0; k < 6; k++)
            applyStimulus(int'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
